fp8_dot_seq: RTL
================

# fp8_dot_seq

Sequencer that accumulates a dot product of `N_TERMS` 8-bit floating-point products through one shared, externally instantiated 8-bit float adder. The adder registers on the clock edge. The block sits between the product stream of the matrix multiplier and the result write-back. It accepts one term per valid/ready handshake, issues accumulate operations to the adder, and presents the finished sum on a valid/ready output.

## Interface
- `N_TERMS`, default 3: terms per dot product (matrix dimension); legal range 1..15
- `CNT_W`, default 4: width of the term counter; must hold `N_TERMS`
- `clkn` in 1: clock, rising-edge active
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: `in_data` holds a term
- `in_ready` out 1: block accepts a term this cycle
- `in_data` in 8: term; bit 7 is sign, [6:4] is exponent, [3:0] is mantissa (hidden 1); [6:0]==0 means zero
- `add_a` out 8: adder operand 1, registered (accumulator side)
- `add_b` out 8: adder operand 2, registered (new term)
- `add_sum` in 8: adder result, valid one edge after the adder samples `add_a`/`add_b`
- `out_valid` out 1: `out_data` holds a finished dot product
- `out_ready` in 1: consumer accepts the result
- `out_data` out 8: accumulated result
- `busy` out 1: state is not IDLE
- `ovf` out 1: present only with `FP8_ACC_OVF_EN` (see Configuration)

## Operation
- Handshake: a transfer occurs on an edge where valid and ready are both 1.
- States: IDLE, ACC, OP1, OP2, DONE. Internal registers are `acc[7:0]` and `cnt[CNT_W-1:0]`.
- **IDLE:** `in_ready`=1.
  - On a handshake: `acc`<=`in_data`, `cnt`<=1.
  - Next state is DONE if `N_TERMS`==1, else ACC.
- **ACC:** `in_ready`=1.
  - On a handshake: `add_a`<=`acc`, `add_b`<=`in_data`, go to OP1.
  - Without a handshake, stay in ACC and hold all registers.
- **OP1:** `in_ready`=0. The adder samples its operands at the edge ending this cycle. Always go to OP2.
- **OP2:** `in_ready`=0.
  - `acc`<=`add_sum`, `cnt`<=`cnt`+1.
  - Go to DONE if `cnt`+1==`N_TERMS`, else ACC.
- **DONE:** `out_valid`=1, `out_data`=`acc`, `in_ready`=0.
  - On an output handshake go to IDLE and set `cnt`<=0.
  - A new dot product starts only after the output handshake; there is no overlap.
- No float arithmetic is done in this block. Zero, alignment and exponent saturation (3'b111) are handled by the adder.
- `add_a`/`add_b` hold their last values outside ACC→OP1 transfers.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `add_a`=0, `add_b`=0, `busy`=0, `ovf`=0, `acc`=0, `cnt`=0, state IDLE.
- Per accumulate: 3 cycles from term handshake to the next ACC (ACC, OP1, OP2).
- Latency with back-to-back terms: `out_valid` rises 1+3·(`N_TERMS`−1) cycles after the first term's handshake edge. That is 7 cycles for `N_TERMS`=3.
- Input stalls (`in_valid`=0 in ACC) add cycle-for-cycle latency.
- Output backpressure holds DONE and `out_data` stable indefinitely.
- `in_valid` asserted in OP1/OP2/DONE is ignored (`in_ready`=0); the term is not consumed.
- Reset mid-operation aborts the partial sum; no `out_valid` is produced for it.

## Configuration
- Macro: `FP8_ACC_OVF_EN`.
- **Defined:**
  - Port `ovf` exists.
  - `ovf` is set sticky when an accepted term or `add_sum` has exponent 3'b111.
  - `ovf` is cleared on the IDLE first-term handshake.
  - While `ovf`=1, ACC handshakes consume terms, increment `cnt` and stay in ACC (or go to DONE on the last term) without issuing adds. `acc` is unchanged.
- **Undefined:** no `ovf` port; every term is issued to the adder.

## Test plan
- `N_TERMS`=3, terms 0x30, 0x30, 0x40 back-to-back, `out_ready`=1 → `out_data`=0x50, `out_valid` 7 cycles after first handshake, held one cycle.
- Terms 0x00, 0x35, 0x00 → `out_data`=0x35 (zero passthrough); `add_a`/`add_b` observed as 0x00/0x35 then 0x35/0x00.
- Terms 0x30, 0x30, 0x40 with `in_valid` dropped for 2 cycles in ACC and `out_ready`=0 for 4 cycles → result 0x50, latency +2, `out_data` stable through backpressure, no term lost or duplicated.
- `rst_n` pulsed low during OP2 of the second term → all outputs at reset values immediately. A following 0x30, 0x30, 0x40 sequence yields 0x50.
- With `FP8_ACC_OVF_EN`: terms 0x70, 0x30, 0x30 → `ovf`=1 after the first term, no adds issued (`add_a`/`add_b` unchanged), `out_data`=0x70. The next dot product clears `ovf`.
- `N_TERMS`=1, term 0x4A → IDLE→DONE, `out_data`=0x4A one cycle after handshake; adder operands untouched.

Source files
------------

// File: rtl/fp8_dot_seq.sv
// Dot-product sequencer: folds N_TERMS fp8 terms into one sum through a shared external adder.
// Optional build macro FP8_ACC_OVF_EN adds a sticky exponent-saturation flag that bypasses further adds.
module fp8_dot_seq #(
    parameter int N_TERMS = 3,
    parameter int CNT_W   = 4
) (
    input  logic             clkn,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    input  logic [7:0]       add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
`ifdef FP8_ACC_OVF_EN
    output logic             ovf,
`endif
    output logic [2:0]       dbg_state
);

    // Handshakes (in_* and out_*): a transfer happens on a rising clkn edge where
    // valid and ready are both 1; ready never depends combinationally on valid.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_OP1  = 3'd2,
        S_OP2  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_TERMS);

    state_t           state;
    logic [7:0]       acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc   = cnt + 1'b1;
    assign in_ready  = (state == S_IDLE) || (state == S_ACC);
    assign out_valid = (state == S_DONE);
    assign out_data  = acc;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

`ifdef FP8_ACC_OVF_EN
    function automatic logic exp_sat(input logic [7:0] v);
        return v[6:4] == 3'b111;
    endfunction
`endif

    always_ff @(posedge clkn or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= 8'h00;
            cnt   <= '0;
            add_a <= 8'h00;
            add_b <= 8'h00;
`ifdef FP8_ACC_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        acc   <= in_data;
                        cnt   <= CNT_W'(1);
`ifdef FP8_ACC_OVF_EN
                        ovf   <= exp_sat(in_data);
`endif
                        state <= (N_TERMS == 1) ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
`ifdef FP8_ACC_OVF_EN
                        // Once saturated the sum is meaningless; just count the terms through.
                        if (ovf) begin
                            cnt   <= cnt_inc;
                            state <= (cnt_inc == N_LAST) ? S_DONE : S_ACC;
                        end else begin
                            add_a <= acc;
                            add_b <= in_data;
                            if (exp_sat(in_data)) ovf <= 1'b1;
                            state <= S_OP1;
                        end
`else
                        add_a <= acc;
                        add_b <= in_data;
                        state <= S_OP1;
`endif
                    end
                end
                S_OP1: begin
                    state <= S_OP2;
                end
                S_OP2: begin
                    acc   <= add_sum;
                    cnt   <= cnt_inc;
`ifdef FP8_ACC_OVF_EN
                    if (exp_sat(add_sum)) ovf <= 1'b1;
`endif
                    state <= (cnt_inc == N_LAST) ? S_DONE : S_ACC;
                end
                S_DONE: begin
                    if (out_ready) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
